// File: rtl/display_scan_sequencer.sv
// Scan counter, character mux and frame-aligned message commit for a 4-digit 7-segment display.
// Optional digit scrolling is enabled by defining DISPLAY_SCROLL_EN.
module display_scan_sequencer #(
    parameter int unsigned PRESCALE      = 4,
    parameter int unsigned SCROLL_FRAMES = 8
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        en_i,
    input  logic [15:0] msg_in_i,
    input  logic        msg_valid_i,
    output logic        msg_ready_o,
    output logic [3:0]  count_o,
    output logic [3:0]  char_out_o,
    output logic        frame_tick_o
);

    localparam int unsigned PW = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0] PrescMax = PW'(PRESCALE - 1);

    if (PRESCALE < 1) begin : gen_bad_prescale
        $error("PRESCALE must be at least 1");
    end
    if (SCROLL_FRAMES < 1) begin : gen_bad_scroll
        $error("SCROLL_FRAMES must be at least 1");
    end

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    count_q, count_d;
    logic [15:0]   msg_reg_q, msg_reg_d;
    logic [15:0]   msg_buf_q, msg_buf_d;
    logic          pending_q, pending_d;
    logic          frame_tick_q, frame_tick_d;

    logic step, fb, accept, commit;

    always_comb begin
        step   = en_i && (presc_q == PrescMax);
        fb     = step && (count_q == 4'h0);
        accept = msg_valid_i && !pending_q;
        // Commit sees the old pending flag, so a same-cycle accept waits for the next frame.
        commit = fb && pending_q;
    end

    always_comb begin
        presc_d = presc_q;
        if (step) begin
            presc_d = '0;
        end else if (en_i) begin
            presc_d = presc_q + 1'b1;
        end

        count_d      = step ? count_q - 4'h1 : count_q;
        msg_buf_d    = accept ? msg_in_i : msg_buf_q;
        frame_tick_d = fb;

        pending_d = pending_q;
        if (commit) begin
            pending_d = 1'b0;
        end else if (accept) begin
            pending_d = 1'b1;
        end
    end

`ifdef DISPLAY_SCROLL_EN
    localparam int unsigned FW = $clog2(SCROLL_FRAMES) + 1;
    localparam logic [FW-1:0] FrameMax = FW'(SCROLL_FRAMES - 1);

    logic [FW-1:0] frame_q, frame_d;

    always_comb begin
        frame_d   = frame_q;
        msg_reg_d = msg_reg_q;
        if (commit) begin
            msg_reg_d = msg_buf_q;
            frame_d   = '0;
        end else if (fb) begin
            if (frame_q == FrameMax) begin
                msg_reg_d = {msg_reg_q[11:0], msg_reg_q[15:12]};
                frame_d   = '0;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end
`else
    always_comb begin
        msg_reg_d = commit ? msg_buf_q : msg_reg_q;
    end
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            presc_q      <= '0;
            count_q      <= 4'hF;
            msg_reg_q    <= '0;
            msg_buf_q    <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            count_q      <= count_d;
            msg_reg_q    <= msg_reg_d;
            msg_buf_q    <= msg_buf_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Digit select follows count[3:2] so each character settles a step before its anode lights.
    always_comb begin
        case (count_q[3:2])
            2'b11:   char_out_o = msg_reg_q[15:12];
            2'b10:   char_out_o = msg_reg_q[11:8];
            2'b01:   char_out_o = msg_reg_q[7:4];
            default: char_out_o = msg_reg_q[3:0];
        endcase
    end

    assign msg_ready_o  = ~pending_q;
    assign count_o      = count_q;
    assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_display_scan_sequencer.sv
// Directed bench for display_scan_sequencer: scan timing, enable freeze, handshake, frame commit,
// mid-run reset and (with DISPLAY_SCROLL_EN) digit rotation.
module tb_display_scan_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        en_i;
    logic [15:0] msg_in_i;
    logic        msg_valid_i;
    logic        msg_ready_o;
    logic [3:0]  count_o;
    logic [3:0]  char_out_o;
    logic        frame_tick_o;

    int n_checks = 0;
    int n_err    = 0;

    display_scan_sequencer #(
        .PRESCALE     (4),
        .SCROLL_FRAMES(2)
    ) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .en_i        (en_i),
        .msg_in_i    (msg_in_i),
        .msg_valid_i (msg_valid_i),
        .msg_ready_o (msg_ready_o),
        .count_o     (count_o),
        .char_out_o  (char_out_o),
        .frame_tick_o(frame_tick_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0] cnt;
        logic [1:0] dig;
    } row_t;

    row_t frame_tab [16];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic wait_fb();
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!frame_tick_o && k < 200);
        n_checks++;
        if (!frame_tick_o) begin
            n_err++;
            $display("FAIL wait_fb: got no frame_tick expected one within 200 cycles");
        end
    endtask

    // Starts at the first cycle of a frame; walks all 16 scan steps and ends on the next one.
    task automatic check_frame(input logic [15:0] msg);
        logic [3:0] exp_ch;
        for (int i = 0; i < 16; i++) begin
            exp_ch = 4'(msg >> (4 * int'(frame_tab[i].dig)));
            chk("frame_count", {12'h0, count_o}, {12'h0, frame_tab[i].cnt});
            chk("frame_char", {12'h0, char_out_o}, {12'h0, exp_ch});
            repeat (4) tick();
        end
    endtask

    initial begin
        logic [3:0]  exp_cnt;
        logic [15:0] old_msg;

        frame_tab = '{
            '{4'hF, 2'd3}, '{4'hE, 2'd3}, '{4'hD, 2'd3}, '{4'hC, 2'd3},
            '{4'hB, 2'd2}, '{4'hA, 2'd2}, '{4'h9, 2'd2}, '{4'h8, 2'd2},
            '{4'h7, 2'd1}, '{4'h6, 2'd1}, '{4'h5, 2'd1}, '{4'h4, 2'd1},
            '{4'h3, 2'd0}, '{4'h2, 2'd0}, '{4'h1, 2'd0}, '{4'h0, 2'd0}
        };

        reset_ni    = 1'b0;
        en_i        = 1'b0;
        msg_in_i    = 16'h0;
        msg_valid_i = 1'b0;

        // Reset values
        #12;
        chk("rst_count", {12'h0, count_o}, 16'h000F);
        chk("rst_char", {12'h0, char_out_o}, 16'h0000);
        chk("rst_ready", {15'h0, msg_ready_o}, 16'h0001);
        chk("rst_tick", {15'h0, frame_tick_o}, 16'h0000);

        tick();
        reset_ni = 1'b1;
        en_i     = 1'b1;

        // Free-running scan: step every 4 cycles, frame_tick only after the 0 -> F step
        for (int n = 1; n <= 90; n++) begin
            tick();
            exp_cnt = 4'((15 - n / 4) & 15);
            chk("scan_count", {12'h0, count_o}, {12'h0, exp_cnt});
            chk("scan_tick", {15'h0, frame_tick_o}, {15'h0, (n == 64)});
        end

        // Freeze at count 9 with prescaler at 2
        en_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("freeze_count", {12'h0, count_o}, 16'h0009);
        end
        en_i = 1'b1;
        tick();
        chk("resume_hold", {12'h0, count_o}, 16'h0009);
        tick();
        chk("resume_step", {12'h0, count_o}, 16'h0008);

        // Handshake: 1234 accepted, 5678 ignored while pending
        wait_fb();
        msg_in_i    = 16'h1234;
        msg_valid_i = 1'b1;
        tick();
        chk("hs_ready_low", {15'h0, msg_ready_o}, 16'h0000);
        msg_in_i = 16'h5678;
        tick();
        tick();
        chk("hs_still_busy", {15'h0, msg_ready_o}, 16'h0000);
        chk("hs_no_tear", {12'h0, char_out_o}, 16'h0000);
        msg_valid_i = 1'b0;
        wait_fb();
        chk("hs_ready_back", {15'h0, msg_ready_o}, 16'h0001);
        check_frame(16'h1234);

        // Accept exactly on the frame boundary: old message stays for a whole frame
        repeat (63) tick();
        chk("pre_fb_count", {12'h0, count_o}, 16'h0000);
        msg_in_i    = 16'hABCD;
        msg_valid_i = 1'b1;
        tick();
        msg_valid_i = 1'b0;
        chk("fbacc_tick", {15'h0, frame_tick_o}, 16'h0001);
        chk("fbacc_ready", {15'h0, msg_ready_o}, 16'h0000);
`ifdef DISPLAY_SCROLL_EN
        old_msg = 16'h2341;
`else
        old_msg = 16'h1234;
`endif
        check_frame(old_msg);
        chk("abcd_ready", {15'h0, msg_ready_o}, 16'h0001);
        check_frame(16'hABCD);

        // Mid-run reset discards a pending message
        repeat (5) tick();
        msg_in_i    = 16'h1111;
        msg_valid_i = 1'b1;
        tick();
        msg_valid_i = 1'b0;
        chk("mr_pending", {15'h0, msg_ready_o}, 16'h0000);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("mr_count", {12'h0, count_o}, 16'h000F);
        chk("mr_char", {12'h0, char_out_o}, 16'h0000);
        chk("mr_ready", {15'h0, msg_ready_o}, 16'h0001);
        chk("mr_tick", {15'h0, frame_tick_o}, 16'h0000);
        #1;
        reset_ni = 1'b1;
        repeat (3) tick();
        chk("mr_rel_hold", {12'h0, count_o}, 16'h000F);
        tick();
        chk("mr_rel_step", {12'h0, count_o}, 16'h000E);
        wait_fb();
        chk("mr_discard_char", {12'h0, char_out_o}, 16'h0000);
        chk("mr_discard_ready", {15'h0, msg_ready_o}, 16'h0001);

`ifdef DISPLAY_SCROLL_EN
        // Rotation every 2 frames; a commit on a scroll boundary loads unrotated
        msg_in_i    = 16'h1234;
        msg_valid_i = 1'b1;
        tick();
        msg_valid_i = 1'b0;
        wait_fb();
        check_frame(16'h1234);
        check_frame(16'h1234);
        check_frame(16'h2341);
        check_frame(16'h2341);
        check_frame(16'h3412);
        msg_in_i    = 16'h5678;
        msg_valid_i = 1'b1;
        tick();
        msg_valid_i = 1'b0;
        wait_fb();
        check_frame(16'h5678);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/display_scan_sequencer.md
Name: display_scan_sequencer

Overview:
Upstream stage of the 4-digit 7-segment anode driver. Generates the 4-bit down-counting scan value that the anode driver decodes into an3..an0, and presents the 4-bit character for the digit about to be lit to the segment decoder. Accepts a new 16-bit message through a valid/ready handshake and commits it only at a frame boundary, so digits never tear mid-frame.

Parameters:
PRESCALE, 4, clk cycles per scan step; legal range >= 1; PRESCALE=1 gives a step every cycle
SCROLL_FRAMES, 8, frames between one-digit rotations; used only with DISPLAY_SCROLL_EN

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
en  input  1  scan enable; low freezes the prescaler and counter
msg_in  input  16  message: [15:12]=digit3 ... [3:0]=digit0
msg_valid  input  1  msg_in is valid
msg_ready  output  1  block can accept a message
count  output  4  scan value for the anode driver (down counter)
char_out  output  4  character for the digit selected by count[3:2]
frame_tick  output  1  one-cycle pulse at the start of each frame

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values: prescaler=0, count=4'hF, msg_reg=0, msg_buf=0, pending=0, msg_ready=1, frame_tick=0, char_out=0.
- Prescaler: width $clog2(PRESCALE)+1. step=en && (presc==PRESCALE-1). On step, presc returns to 0; otherwise it increments while en=1. With en=0, presc and count hold.
- Counter: on step, count decrements by 1. Wraps 0 -> F; this wrap is the frame boundary (fb=step && count==0).
- Anode alignment: the driver lights an3/an2/an1/an0 at counts E/A/6/2.
- char_out: combinational mux on registered state with no latency. count[3:2]=11 selects msg_reg[15:12], 10 selects [11:8], 01 selects [7:4], 00 selects [3:0]. Data is therefore stable at least one step before and during each lit count.
- Handshake:
  - msg_ready = ~pending.
  - When msg_valid && msg_ready, msg_buf<=msg_in and pending<=1 in that cycle.
  - msg_valid with msg_ready=0 is ignored. The source holds msg_valid until it sees ready.
- Commit: on fb with pending=1, msg_reg<=msg_buf and pending<=0, so msg_ready rises the next cycle.
- Simultaneous events: an accept in the same cycle as fb (pending was 0) is not committed at that fb; it commits at the next fb. No accept and commit can occur in the same cycle for the same buffer because accept requires pending=0.
- frame_tick: registered, equals fb delayed one cycle. It is high during the first cycle with count=F.
- Reset mid-operation: all state returns to reset values immediately. A pending message is discarded.
- Widths: all counters are unsigned. No other arithmetic.

Optional Feature:
Macro DISPLAY_SCROLL_EN.
- Defined:
  - A frame counter (width $clog2(SCROLL_FRAMES)+1, reset 0) increments on each fb.
  - When it reaches SCROLL_FRAMES-1 on fb with pending=0, msg_reg rotates left one digit ({msg_reg[11:0],msg_reg[15:12]}) and the counter clears.
  - A commit on fb has priority over rotation and clears the frame counter.
  - en=0 freezes the frame counter.
- Undefined: no frame counter and no rotation logic. msg_reg changes only on commit.

Test Plan:
1. Reset: assert reset_n=0 mid-run -> count=F, char_out=0, msg_ready=1, frame_tick=0 immediately. Release -> count first steps to E after PRESCALE cycles.
2. PRESCALE=4, en=1 for 64 cycles -> count steps F,E,...,0,F every 4 cycles. frame_tick is high exactly once, in the cycle after the 0->F step.
3. en=0 for 10 cycles at count=9 with presc=2 -> count stays 9 and presc stays 2. Resume -> next step after 1 cycle.
4. Handshake: send msg_in=16'h1234 with valid -> msg_ready=0 next cycle. Send 16'h5678 while not ready -> ignored. At fb, char_out shows 1 at counts F-C, 2 at B-8, 3 at 7-4, 4 at 3-0. msg_ready returns to 1.
5. Accept 16'hABCD in the exact fb cycle -> display keeps the old message for the whole next frame. ABCD appears after the following fb.
6. DISPLAY_SCROLL_EN, SCROLL_FRAMES=2, msg=16'h1234 -> after 2 frames msg_reg=16'h2341, after 4 frames 16'h3412. A commit at a scroll boundary loads the new message unrotated.
